// File: rtl/spi_word_master_if.sv
// Word-wide request/response bus plus SPI pins of spi_word_master.
// The master modport is the SPI master's view; slave is the user/pad side.
interface spi_word_master_if #(
    parameter int WORD_BITS = 32
);
    logic [WORD_BITS-1:0] i_TX_Word;
    logic                 i_TX_DV;
    logic                 o_TX_Ready;
    logic [WORD_BITS-1:0] o_RX_Word;
    logic                 o_RX_DV;
    logic                 o_SPI_Clk;
    logic                 i_SPI_MISO;
    logic                 o_SPI_MOSI;
    logic                 o_SPI_CS_n;

    modport master (
        input  i_TX_Word, i_TX_DV, i_SPI_MISO,
        output o_TX_Ready, o_RX_Word, o_RX_DV, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );

    modport slave (
        output i_TX_Word, i_TX_DV, i_SPI_MISO,
        input  o_TX_Ready, o_RX_Word, o_RX_DV, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );
endinterface

// File: rtl/spi_word_master.sv
// SPI master moving one WORD_BYTES-wide word per chip-select frame,
// all four SPI modes, either bit order, programmable SCLK divider and CS gap.
module spi_word_master #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int WORD_BYTES        = 4,
    parameter int MSB_FIRST         = 1,
    parameter int CS_INACTIVE_CLKS  = 1
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    spi_word_master_if.master  bus
);
    localparam int   N    = 8 * WORD_BYTES;
    localparam logic CPOL = (SPI_MODE >= 2);
    localparam logic CPHA = ((SPI_MODE % 2) == 1);
    localparam int   HW   = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam int   EW   = $clog2(2 * N + 1);
    localparam int   GW   = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;

    localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * N - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_INACTIVE_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic [HW-1:0]  half_cnt_r;
    logic [EW-1:0]  edge_cnt_r;
    logic [GW-1:0]  gap_cnt_r;
    logic [N-1:0]   tx_shift_r, rx_shift_r;
    logic [N-1:0]   tx_next_s, rx_next_s;
    logic           sclk_r, mosi_r, cs_n_r, ready_r, rx_dv_r;
    logic [N-1:0]   rx_word_r;
    logic           accept_s, half_done_s, edge_s, odd_edge_s, sample_s, advance_s;

    function automatic logic first_bit(input logic [N-1:0] w);
        first_bit = (MSB_FIRST != 0) ? w[N-1] : w[0];
    endfunction

    // Edge decode: edge number k = edge_cnt_r + 1, so k is odd when edge_cnt_r is even
    always_comb begin
        accept_s    = (state_r == IDLE) && bus.i_TX_DV;
        half_done_s = (half_cnt_r == HALF_LAST);
        edge_s      = (state_r == SHIFT) && half_done_s;
        odd_edge_s  = ~edge_cnt_r[0];
        sample_s    = edge_s && (CPHA ? ~odd_edge_s : odd_edge_s);
        advance_s   = edge_s && (CPHA ? (odd_edge_s && (edge_cnt_r >= EW'(2)))
                                      : (~odd_edge_s && (edge_cnt_r != EDGE_LAST)));
        tx_next_s   = (MSB_FIRST != 0) ? {tx_shift_r[N-2:0], 1'b0}
                                       : {1'b0, tx_shift_r[N-1:1]};
        rx_next_s   = (MSB_FIRST != 0) ? {rx_shift_r[N-2:0], bus.i_SPI_MISO}
                                       : {bus.i_SPI_MISO, rx_shift_r[N-1:1]};
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? SHIFT : IDLE;
            SHIFT:   state_s = (edge_s && (edge_cnt_r == EDGE_LAST)) ? HOLD : SHIFT;
            HOLD:    state_s = half_done_s ? GAP : HOLD;
            GAP:     state_s = (gap_cnt_r == GAP_LAST) ? IDLE : GAP;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Half-bit, edge and CS-gap counters; each restarts whenever its phase begins
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            half_cnt_r <= '0;
            edge_cnt_r <= '0;
            gap_cnt_r  <= '0;
        end else begin
            if (((state_r == SHIFT) || (state_r == HOLD)) && !half_done_s) begin
                half_cnt_r <= half_cnt_r + HW'(1);
            end else begin
                half_cnt_r <= '0;
            end
            if (state_r == IDLE) begin
                edge_cnt_r <= '0;
            end else if (edge_s) begin
                edge_cnt_r <= edge_cnt_r + EW'(1);
            end
            if (state_r == GAP) begin
                gap_cnt_r <= gap_cnt_r + GW'(1);
            end else begin
                gap_cnt_r <= '0;
            end
        end
    end

    // Shift registers, SCLK and MOSI; MOSI keeps its last bit between frames
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tx_shift_r <= '0;
            rx_shift_r <= '0;
            sclk_r     <= CPOL;
            mosi_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                tx_shift_r <= bus.i_TX_Word;
                rx_shift_r <= '0;
                mosi_r     <= first_bit(bus.i_TX_Word);
            end else if (advance_s) begin
                tx_shift_r <= tx_next_s;
                mosi_r     <= first_bit(tx_next_s);
            end
            if (sample_s) begin
                rx_shift_r <= rx_next_s;
            end
            if (edge_s) begin
                sclk_r <= ~sclk_r;
            end
        end
    end

    // Registered status outputs follow the state being entered
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cs_n_r    <= 1'b1;
            ready_r   <= 1'b1;
            rx_dv_r   <= 1'b0;
            rx_word_r <= '0;
        end else begin
            cs_n_r  <= !((state_s == SHIFT) || (state_s == HOLD));
            ready_r <= (state_s == IDLE);
            rx_dv_r <= (state_r == HOLD) && (state_s == GAP);
            if ((state_r == HOLD) && (state_s == GAP)) begin
                rx_word_r <= rx_shift_r;
            end
        end
    end

    assign bus.o_TX_Ready = ready_r;
    assign bus.o_RX_Word  = rx_word_r;
    assign bus.o_RX_DV    = rx_dv_r;
    assign bus.o_SPI_Clk  = sclk_r;
    assign bus.o_SPI_MOSI = mosi_r;
    assign bus.o_SPI_CS_n = cs_n_r;
endmodule

// File: tb/tb_spi_word_master.sv
// Directed bench for spi_word_master: four configurations, loopback or slave model,
// frame timing, back-to-back frames and mid-frame reset.
module tb_spi_word_master;
    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic [31:0] tx_word;
    logic        tx_dv;
    logic        slave_miso;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    spi_word_master_if #(.WORD_BITS(32)) if0 ();
    spi_word_master_if #(.WORD_BITS(16)) if1 ();
    spi_word_master_if #(.WORD_BITS(8))  if2 ();
    spi_word_master_if #(.WORD_BITS(24)) if3 ();

    spi_word_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2), .WORD_BYTES(4), .MSB_FIRST(1),
                      .CS_INACTIVE_CLKS(3)) u0 (.i_Clk(clk), .i_Rst(rst), .bus(if0));
    spi_word_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(1), .WORD_BYTES(2), .MSB_FIRST(1),
                      .CS_INACTIVE_CLKS(1)) u1 (.i_Clk(clk), .i_Rst(rst), .bus(if1));
    spi_word_master #(.SPI_MODE(1), .CLKS_PER_HALF_BIT(2), .WORD_BYTES(1), .MSB_FIRST(0),
                      .CS_INACTIVE_CLKS(1)) u2 (.i_Clk(clk), .i_Rst(rst), .bus(if2));
    spi_word_master #(.SPI_MODE(2), .CLKS_PER_HALF_BIT(5), .WORD_BYTES(3), .MSB_FIRST(1),
                      .CS_INACTIVE_CLKS(2)) u3 (.i_Clk(clk), .i_Rst(rst), .bus(if3));

    assign if0.i_TX_Word  = tx_word;
    assign if1.i_TX_Word  = tx_word[15:0];
    assign if2.i_TX_Word  = tx_word[7:0];
    assign if3.i_TX_Word  = tx_word[23:0];
    assign if0.i_TX_DV    = tx_dv && (sel == 0);
    assign if1.i_TX_DV    = tx_dv && (sel == 1);
    assign if2.i_TX_DV    = tx_dv && (sel == 2);
    assign if3.i_TX_DV    = tx_dv && (sel == 3);
    assign if0.i_SPI_MISO = if0.o_SPI_MOSI;
    assign if2.i_SPI_MISO = if2.o_SPI_MOSI;
    assign if1.i_SPI_MISO = slave_miso;
    assign if3.i_SPI_MISO = slave_miso;

    logic        cs_m, sclk_m, mosi_m, ready_m, rx_dv_m;
    logic [31:0] rx_m;

    always_comb begin
        cs_m = 1'b1; sclk_m = 1'b0; mosi_m = 1'b0; ready_m = 1'b0; rx_dv_m = 1'b0; rx_m = 32'h0;
        case (sel)
            0: begin cs_m = if0.o_SPI_CS_n; sclk_m = if0.o_SPI_Clk; mosi_m = if0.o_SPI_MOSI;
                     ready_m = if0.o_TX_Ready; rx_dv_m = if0.o_RX_DV; rx_m = if0.o_RX_Word; end
            1: begin cs_m = if1.o_SPI_CS_n; sclk_m = if1.o_SPI_Clk; mosi_m = if1.o_SPI_MOSI;
                     ready_m = if1.o_TX_Ready; rx_dv_m = if1.o_RX_DV; rx_m = {16'h0, if1.o_RX_Word}; end
            2: begin cs_m = if2.o_SPI_CS_n; sclk_m = if2.o_SPI_Clk; mosi_m = if2.o_SPI_MOSI;
                     ready_m = if2.o_TX_Ready; rx_dv_m = if2.o_RX_DV; rx_m = {24'h0, if2.o_RX_Word}; end
            3: begin cs_m = if3.o_SPI_CS_n; sclk_m = if3.o_SPI_Clk; mosi_m = if3.o_SPI_MOSI;
                     ready_m = if3.o_TX_Ready; rx_dv_m = if3.o_RX_DV; rx_m = {8'h0, if3.o_RX_Word}; end
            default: ;
        endcase
    end

    typedef struct {
        int          sel;
        int          cpha;
        logic        cpol;
        int          nbits;
        logic        msb;
        int          csi;
        logic [31:0] tx;
        logic [31:0] stx;
        logic [31:0] exp_rx;
        logic [31:0] exp_cap;
        int          exp_cs_low;
        int          exp_edges;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic [31:0] w, input int j, input int n, input logic msb);
        return msb ? w[n-1-j] : w[j];
    endfunction

    // One frame on the selected DUT; acts as the SPI slave and measures timing
    task automatic run_frame(input vec_t v);
        int cs_low = 0, edges = 0, gap = 0, dvc = 0, sb = 0, ncap = 0;
        logic prev_sclk, done, cs_at_dv;
        logic [31:0] rx_got, cap, mask;
        cap = 32'h0; rx_got = 32'h0; cs_at_dv = 1'b0; done = 1'b0;
        mask = (v.nbits == 32) ? 32'hFFFF_FFFF : ((32'h1 << v.nbits) - 32'h1);
        @(negedge clk);
        sel = v.sel; tx_word = v.tx; slave_miso = 1'b0; tx_dv = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        chk("accept_cs_ready", {30'h0, cs_m, ready_m}, 32'h0);
        prev_sclk = v.cpol;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (!cs_m) begin
                cs_low++;
                if (v.cpha == 0 && cs_low == 1) begin
                    slave_miso = bit_of(v.stx, 0, v.nbits, v.msb);
                    sb = 1;
                end
            end
            if (sclk_m !== prev_sclk) begin
                edges++;
                prev_sclk = sclk_m;
                if (((edges % 2) == 1) == (v.cpha == 0)) begin
                    if (v.msb) cap = {cap[30:0], mosi_m};
                    else if (ncap < 32) cap[ncap] = mosi_m;
                    ncap++;
                end else if (sb < v.nbits) begin
                    slave_miso = bit_of(v.stx, sb, v.nbits, v.msb);
                    sb++;
                end
            end
            if (rx_dv_m) begin
                dvc++;
                rx_got = rx_m;
                cs_at_dv = cs_m;
            end
            if (cs_m && !ready_m && cs_low > 0) gap++;
            if (ready_m) done = 1'b1;
        end
        chk("frame_done", {31'h0, done}, 32'h1);
        chk("rx_word", rx_got, v.exp_rx);
        chk("slave_capture", cap & mask, v.exp_cap);
        chk("cs_low_cycles", cs_low, v.exp_cs_low);
        chk("sclk_edges", edges, v.exp_edges);
        chk("rx_dv_pulses", dvc, 32'd1);
        chk("cs_high_at_dv", {31'h0, cs_at_dv}, 32'h1);
        chk("gap_cycles", gap, v.csi);
        chk("sclk_idle", {31'h0, sclk_m}, {31'h0, v.cpol});
    endtask

    int          falls, gap_hi, dvc2, post, tstart, edges_r, dv_after;
    logic        prev_cs, prev_sclk_r;
    logic [31:0] w0, w1;
    vec_t        vdb;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 0; tx_word = 32'h0; tx_dv = 1'b0; slave_miso = 1'b0;
        vecs[0] = '{0, 0, 1'b0, 32, 1'b1, 3, 32'hA5C30F81, 32'h0,      32'hA5C30F81, 32'hA5C30F81, 130, 64};
        vecs[1] = '{0, 0, 1'b0, 32, 1'b1, 3, 32'h80000001, 32'h0,      32'h80000001, 32'h80000001, 130, 64};
        vecs[2] = '{1, 1, 1'b1, 16, 1'b1, 1, 32'h00001234, 32'h3C5A,   32'h00003C5A, 32'h00001234, 33,  32};
        vecs[3] = '{1, 1, 1'b1, 16, 1'b1, 1, 32'h0000FFFF, 32'h8001,   32'h00008001, 32'h0000FFFF, 33,  32};
        vecs[4] = '{2, 1, 1'b0, 8,  1'b0, 1, 32'h00000001, 32'h0,      32'h00000001, 32'h00000001, 34,  16};
        vecs[5] = '{2, 1, 1'b0, 8,  1'b0, 1, 32'h000000B4, 32'h0,      32'h000000B4, 32'h000000B4, 34,  16};
        vecs[6] = '{3, 0, 1'b1, 24, 1'b1, 2, 32'h00C0FFEE, 32'h5A0F33, 32'h005A0F33, 32'h00C0FFEE, 245, 48};
        vecs[7] = '{3, 0, 1'b1, 24, 1'b1, 2, 32'h00000001, 32'hFFFFFE, 32'h00FFFFFE, 32'h00000001, 245, 48};

        repeat (3) @(negedge clk);
        chk("rst_cs_n",  {31'h0, if0.o_SPI_CS_n}, 32'h1);
        chk("rst_sclk0", {31'h0, if0.o_SPI_Clk},  32'h0);
        chk("rst_sclk3", {31'h0, if1.o_SPI_Clk},  32'h1);
        chk("rst_mosi",  {31'h0, if0.o_SPI_MOSI}, 32'h0);
        chk("rst_ready", {31'h0, if0.o_TX_Ready}, 32'h1);
        chk("rst_rx_dv", {31'h0, if0.o_RX_DV},    32'h0);
        chk("rst_rx",    if0.o_RX_Word,           32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // Back-to-back frames with i_TX_DV held, then toggled inside the second frame
        @(negedge clk);
        sel = 0; tx_word = 32'h1111_1111; tx_dv = 1'b1;
        falls = 0; gap_hi = 0; dvc2 = 0; post = 0; tstart = 0; prev_cs = 1'b1;
        w0 = 32'h0; w1 = 32'h0;
        for (int cyc = 0; cyc < 1500 && post < 20; cyc++) begin
            @(negedge clk);
            if (prev_cs && !cs_m) begin
                falls++;
                if (falls == 1) tx_word = 32'h2222_2222;
                if (falls == 2) tstart = cyc;
            end
            if (rx_dv_m) begin
                if (dvc2 == 0) w0 = rx_m;
                else w1 = rx_m;
                dvc2++;
            end
            if (falls == 1 && cs_m && dvc2 >= 1) gap_hi++;
            if (falls >= 2) tx_dv = (cyc - tstart < 40) ? ~tx_dv : 1'b0;
            if (falls >= 2 && ready_m && (cyc - tstart) > 40) post++;
            prev_cs = cs_m;
        end
        tx_dv = 1'b0;
        chk("b2b_frames", falls, 32'd2);
        chk("b2b_dv_pulses", dvc2, 32'd2);
        chk("b2b_word0", w0, 32'h1111_1111);
        chk("b2b_word1", w1, 32'h2222_2222);
        chk("b2b_cs_high", gap_hi, 32'd4);

        // Reset after edge 20 of a frame
        @(negedge clk);
        sel = 0; tx_word = 32'hFFFF_FFFF; tx_dv = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        edges_r = 0; prev_sclk_r = 1'b0;
        for (int cyc = 0; cyc < 300 && edges_r < 20; cyc++) begin
            @(negedge clk);
            if (sclk_m !== prev_sclk_r) begin
                edges_r++;
                prev_sclk_r = sclk_m;
            end
        end
        chk("abort_reached_edge20", edges_r, 32'd20);
        chk("abort_mosi_before", {31'h0, if0.o_SPI_MOSI}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_cs_n",  {31'h0, if0.o_SPI_CS_n}, 32'h1);
        chk("abort_sclk",  {31'h0, if0.o_SPI_Clk},  32'h0);
        chk("abort_mosi",  {31'h0, if0.o_SPI_MOSI}, 32'h0);
        chk("abort_rx",    if0.o_RX_Word,           32'h0);
        chk("abort_ready", {31'h0, if0.o_TX_Ready}, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dv_after = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (rx_dv_m || !cs_m) dv_after++;
        end
        chk("abort_no_dv_no_cs", dv_after, 32'd0);
        vdb = '{0, 0, 1'b0, 32, 1'b1, 3, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 130, 64};
        run_frame(vdb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
